// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core pipeline stages (XLEN = 32).
package letc_core_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NONE,
    MEM_OP_LOAD,
    MEM_OP_STORE,
    MEM_OP_AMO
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } mem_size_e;

  typedef enum logic [3:0] {
    AMO_SWAP,
    AMO_ADD,
    AMO_XOR,
    AMO_AND,
    AMO_OR,
    AMO_MIN,
    AMO_MAX,
    AMO_MINU,
    AMO_MAXU
  } amo_op_e;

  typedef enum logic [1:0] {
    RD_SRC_ALU,
    RD_SRC_CSR,
    RD_SRC_MEM
  } rd_src_e;

  typedef struct packed {
    logic [31:0] pc;
    rd_src_e     rd_src;
    logic [4:0]  rd_idx;
    logic        rd_we;
    logic        csr_expl_wen;
    logic [11:0] csr_idx;
    logic [31:0] csr_old_val;
    logic [31:0] csr_new_val;
    logic [31:0] alu_result;
    mem_op_e     mem_op;
    logic        mem_signed;
    mem_size_e   mem_size;
    amo_op_e     amo_alu_op;
    logic [31:0] rs2_val;
  } m1_to_m2_s;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_idx;
    logic        rd_we;
    logic [31:0] rd_val;
    logic        csr_expl_wen;
    logic [11:0] csr_idx;
    logic [31:0] csr_new_val;
  } m2_to_w_s;

endpackage

// File: rtl/letc_core_stage_memory2_if.sv
// Forwarding-network link: a stage publishes its pending rd write and value.
interface letc_core_forwarder_if;
  logic        rd_we;
  logic [4:0]  rd_idx;
  logic [31:0] fwd_val;
  logic        fwd_val_avail;

  modport stage (output rd_we, rd_idx, fwd_val, fwd_val_avail);
  modport slave (input  rd_we, rd_idx, fwd_val, fwd_val_avail);
endinterface

// File: rtl/letc_core_stage_memory2.sv
// LETC Memory 2 stage: load response collection, store/AMO issue, load
// alignment and rd selection for Writeback and forwarding.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for / evaluating the instruction in the input register
// LOAD_WAIT | load or AMO waiting for its DMSS response
// STORE_REQ | store request held until DMSS accepts it
// AMO_STORE | AMO write-back of op(old, rs2) pending acceptance
// DRAIN     | flushed load: swallow its response, then go IDLE
module letc_core_stage_memory2
  import letc_core_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        m2_ready,
  input  logic                        m2_flush,
  input  logic                        m2_stall,
  input  logic                        m1_to_m2_valid,
  input  m1_to_m2_s                   m1_to_m2,
  output logic                        m2_to_w_valid,
  output m2_to_w_s                    m2_to_w,
  input  logic                        dmss_load_rsp_valid,
  input  logic [31:0]                 dmss_load_rsp_data,
  output logic                        dmss_store_req_valid,
  input  logic                        dmss_store_ready,
  output logic [31:0]                 dmss_store_addr,
  output logic [31:0]                 dmss_store_data,
  output logic [3:0]                  dmss_store_be,
  letc_core_forwarder_if.stage        m2_forwarder
);

  typedef enum logic [2:0] {IDLE, LOAD_WAIT, STORE_REQ, AMO_STORE, DRAIN} state_e;

  state_e      state, state_d;
  logic        ff_in_valid;
  m1_to_m2_s   ff_in;
  logic        rsp_buf_valid;
  logic [31:0] rsp_buf_data;
  logic [31:0] amo_old, amo_new;

  logic        have_data, is_mem_rd;
  logic        done, drop, retire, in_take;
  logic        rsp_consume, store_req, amo_capture;
  logic [31:0] mem_word, ld_word, ld_val, amo_result, rd_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign m2_ready  = (state == IDLE);
  assign have_data = rsp_buf_valid || dmss_load_rsp_valid;
  assign is_mem_rd = (ff_in.mem_op == MEM_OP_LOAD) || (ff_in.mem_op == MEM_OP_AMO);
  assign mem_word  = rsp_buf_valid ? rsp_buf_data : dmss_load_rsp_data;
  assign retire    = done || drop;
  // Only refill when the held instruction is gone, so a multi-cycle op is never overwritten.
  assign in_take   = !m2_stall && m2_ready && (!ff_in_valid || retire);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Input valid and response-buffer valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_in_valid   <= 1'b0;
      rsp_buf_valid <= 1'b0;
    end else begin
      if (in_take)     ff_in_valid <= m1_to_m2_valid;
      else if (retire) ff_in_valid <= 1'b0;
      if (rsp_consume)              rsp_buf_valid <= 1'b0;
      else if (dmss_load_rsp_valid) rsp_buf_valid <= 1'b1;
    end
  end

  // Datapath registers (no reset needed; qualified by the valid flags)
  always_ff @(posedge clk) begin
    if (in_take) ff_in <= m1_to_m2;
    if (dmss_load_rsp_valid && !rsp_consume) rsp_buf_data <= dmss_load_rsp_data;
    if (amo_capture) begin
      amo_old <= mem_word;
      amo_new <= amo_result;
    end
  end

  // Next-state and handshake decode; a stall freezes all progress except response buffering
  always_comb begin
    state_d     = state;
    done        = 1'b0;
    drop        = 1'b0;
    rsp_consume = 1'b0;
    store_req   = 1'b0;
    amo_capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (ff_in_valid) begin
          if (m2_flush) begin
            drop        = 1'b1;
            rsp_consume = is_mem_rd && have_data;
          end else if (!m2_stall) begin
            unique case (ff_in.mem_op)
              MEM_OP_LOAD: begin
                if (have_data) begin
                  done        = 1'b1;
                  rsp_consume = 1'b1;
                end else state_d = LOAD_WAIT;
              end
              MEM_OP_STORE: begin
                store_req = 1'b1;
                if (dmss_store_ready) done = 1'b1;
                else                  state_d = STORE_REQ;
              end
              MEM_OP_AMO: begin
                if (have_data) begin
                  rsp_consume = 1'b1;
                  amo_capture = 1'b1;
                  state_d     = AMO_STORE;
                end else state_d = LOAD_WAIT;
              end
              default: done = 1'b1;
            endcase
          end
        end
      end
      LOAD_WAIT: begin
        if (m2_flush) begin
          drop = 1'b1;
          if (have_data) begin
            rsp_consume = 1'b1;
            state_d     = IDLE;
          end else state_d = DRAIN;
        end else if (!m2_stall && have_data) begin
          rsp_consume = 1'b1;
          if (ff_in.mem_op == MEM_OP_AMO) begin
            amo_capture = 1'b1;
            state_d     = AMO_STORE;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      STORE_REQ, AMO_STORE: begin
        if (m2_flush) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else if (!m2_stall) begin
          store_req = 1'b1;
          if (dmss_store_ready) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (have_data) begin
          rsp_consume = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // AMO arithmetic on the freshly returned memory word
  always_comb begin
    amo_result = ff_in.rs2_val;
    unique case (ff_in.amo_alu_op)
      AMO_SWAP: amo_result = ff_in.rs2_val;
      AMO_ADD:  amo_result = mem_word + ff_in.rs2_val;
      AMO_XOR:  amo_result = mem_word ^ ff_in.rs2_val;
      AMO_AND:  amo_result = mem_word & ff_in.rs2_val;
      AMO_OR:   amo_result = mem_word | ff_in.rs2_val;
      AMO_MIN:  amo_result = ($signed(mem_word) < $signed(ff_in.rs2_val)) ? mem_word : ff_in.rs2_val;
      AMO_MAX:  amo_result = ($signed(mem_word) > $signed(ff_in.rs2_val)) ? mem_word : ff_in.rs2_val;
      AMO_MINU: amo_result = (mem_word < ff_in.rs2_val) ? mem_word : ff_in.rs2_val;
      AMO_MAXU: amo_result = (mem_word > ff_in.rs2_val) ? mem_word : ff_in.rs2_val;
      default:  amo_result = ff_in.rs2_val;
    endcase
  end

  // Load lane selection, extension and rd source mux
  always_comb begin
    ld_word = (state == AMO_STORE) ? amo_old : mem_word;
    unique case (ff_in.alu_result[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ff_in.alu_result[1] ? ld_word[31:16] : ld_word[15:0];
    unique case (ff_in.mem_size)
      SIZE_BYTE: ld_val = {{24{ff_in.mem_signed & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_val = {{16{ff_in.mem_signed & ld_half[15]}}, ld_half};
      default:   ld_val = ld_word;
    endcase
    unique case (ff_in.rd_src)
      RD_SRC_CSR: rd_val = ff_in.csr_old_val;
      RD_SRC_MEM: rd_val = ld_val;
      default:    rd_val = ff_in.alu_result;
    endcase
  end

  // Store lane encoding; AMO write-back is always a full word
  always_comb begin
    dmss_store_be   = 4'hF;
    dmss_store_data = ff_in.rs2_val;
    if (state == AMO_STORE) begin
      dmss_store_data = amo_new;
    end else begin
      unique case (ff_in.mem_size)
        SIZE_BYTE: begin
          dmss_store_be   = 4'b0001 << ff_in.alu_result[1:0];
          dmss_store_data = {4{ff_in.rs2_val[7:0]}};
        end
        SIZE_HALF: begin
          dmss_store_be   = 4'b0011 << {ff_in.alu_result[1], 1'b0};
          dmss_store_data = {2{ff_in.rs2_val[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign dmss_store_req_valid = store_req;
  assign dmss_store_addr      = {ff_in.alu_result[31:2], 2'b00};

  assign m2_to_w_valid        = done;
  assign m2_to_w.pc           = ff_in.pc;
  assign m2_to_w.rd_idx       = ff_in.rd_idx;
  assign m2_to_w.rd_we        = ff_in.rd_we;
  assign m2_to_w.rd_val       = rd_val;
  assign m2_to_w.csr_expl_wen = ff_in.csr_expl_wen;
  assign m2_to_w.csr_idx      = ff_in.csr_idx;
  assign m2_to_w.csr_new_val  = ff_in.csr_new_val;

  assign m2_forwarder.rd_we         = ff_in_valid && ff_in.rd_we;
  assign m2_forwarder.rd_idx        = ff_in.rd_idx;
  assign m2_forwarder.fwd_val       = rd_val;
  assign m2_forwarder.fwd_val_avail = (ff_in.rd_src != RD_SRC_MEM) || (state == AMO_STORE) || have_data;

endmodule

// File: tb/tb_letc_core_stage_memory2.sv
// Self-checking bench for letc_core_stage_memory2: directed cases plus random
// transactions checked against a behavioural memory-access model.
module tb_letc_core_stage_memory2;
  import letc_core_pkg::*;

  logic        clk, rst_n;
  logic        m2_ready, m2_flush, m2_stall;
  logic        m1_to_m2_valid;
  m1_to_m2_s   m1_to_m2;
  logic        m2_to_w_valid;
  m2_to_w_s    m2_to_w;
  logic        dmss_load_rsp_valid;
  logic [31:0] dmss_load_rsp_data;
  logic        dmss_store_req_valid, dmss_store_ready;
  logic [31:0] dmss_store_addr, dmss_store_data;
  logic [3:0]  dmss_store_be;

  letc_core_forwarder_if fwd_if ();

  letc_core_stage_memory2 dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .m2_ready            (m2_ready),
    .m2_flush            (m2_flush),
    .m2_stall            (m2_stall),
    .m1_to_m2_valid      (m1_to_m2_valid),
    .m1_to_m2            (m1_to_m2),
    .m2_to_w_valid       (m2_to_w_valid),
    .m2_to_w             (m2_to_w),
    .dmss_load_rsp_valid (dmss_load_rsp_valid),
    .dmss_load_rsp_data  (dmss_load_rsp_data),
    .dmss_store_req_valid(dmss_store_req_valid),
    .dmss_store_ready    (dmss_store_ready),
    .dmss_store_addr     (dmss_store_addr),
    .dmss_store_data     (dmss_store_data),
    .dmss_store_be       (dmss_store_be),
    .m2_forwarder        (fwd_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                           input mem_size_e sz, input logic sgn);
    logic [31:0] v;
    int lane;
    case (sz)
      SIZE_BYTE: begin
        lane = int'(addr % 4);
        v = (w >> (8 * lane)) & 32'hFF;
        if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      SIZE_HALF: begin
        lane = int'((addr % 4) / 2);
        v = (w >> (16 * lane)) & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_amo(input amo_op_e op, input logic [31:0] old, input logic [31:0] rs2);
    case (op)
      AMO_ADD:  return old + rs2;
      AMO_XOR:  return old ^ rs2;
      AMO_AND:  return old & rs2;
      AMO_OR:   return old | rs2;
      AMO_MIN:  return ($signed(old) < $signed(rs2)) ? old : rs2;
      AMO_MAX:  return ($signed(old) > $signed(rs2)) ? old : rs2;
      AMO_MINU: return (old < rs2) ? old : rs2;
      AMO_MAXU: return (old > rs2) ? old : rs2;
      default:  return rs2;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input m1_to_m2_s b);
    case (b.mem_size)
      SIZE_BYTE: return 4'(1 << (b.alu_result % 4));
      SIZE_HALF: return 4'(3 << (2 * ((b.alu_result % 4) / 2)));
      default:   return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_sdata(input m1_to_m2_s b);
    case (b.mem_size)
      SIZE_BYTE: return (b.rs2_val & 32'hFF) * 32'h01010101;
      SIZE_HALF: return (b.rs2_val & 32'hFFFF) * 32'h00010001;
      default:   return b.rs2_val;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input m1_to_m2_s b, input logic [31:0] mem);
    case (b.rd_src)
      RD_SRC_CSR: return b.csr_old_val;
      RD_SRC_MEM: return ref_load(mem, b.alu_result, b.mem_size, b.mem_signed);
      default:    return b.alu_result;
    endcase
  endfunction

  function automatic m1_to_m2_s mk(input mem_op_e op, input mem_size_e sz, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] rs2,
                                   input rd_src_e src, input amo_op_e aop);
    m1_to_m2_s b;
    b.pc           = $urandom & 32'hFFFF_FFFC;
    b.rd_src       = src;
    b.rd_idx       = 5'($urandom_range(1, 31));
    b.rd_we        = (op != MEM_OP_STORE);
    b.csr_expl_wen = 1'($urandom);
    b.csr_idx      = 12'($urandom);
    b.csr_old_val  = $urandom;
    b.csr_new_val  = $urandom;
    b.alu_result   = addr;
    b.mem_op       = op;
    b.mem_signed   = sgn;
    b.mem_size     = sz;
    b.amo_alu_op   = aop;
    b.rs2_val      = rs2;
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic quiet_inputs();
    m1_to_m2_valid      = 1'b0;
    dmss_load_rsp_valid = 1'b0;
    dmss_load_rsp_data  = $urandom;
    dmss_store_ready    = 1'b0;
    m2_flush            = 1'b0;
    m2_stall            = 1'b0;
  endtask

  task automatic issue(input m1_to_m2_s b);
    @(negedge clk);
    quiet_inputs();
    m1_to_m2_valid = 1'b1;
    m1_to_m2       = b;
    #1;
    check("issue_ready", 32'(m2_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input m1_to_m2_s b, input logic [31:0] exp_rd);
    check({tag, "_rd_val"}, m2_to_w.rd_val, exp_rd);
    check({tag, "_rd_idx"}, 32'(m2_to_w.rd_idx), 32'(b.rd_idx));
    check({tag, "_pc"}, m2_to_w.pc, b.pc);
    check({tag, "_fwd_val"}, fwd_if.fwd_val, exp_rd);
  endtask

  // One complete instruction: lat = response delay, dly = store-ready delay.
  task automatic run_txn(input m1_to_m2_s b, input logic [31:0] mem, input int lat, input int dly);
    logic [31:0] exp_rd;
    exp_rd = ref_rd(b, mem);
    issue(b);
    if (b.mem_op == MEM_OP_NONE) begin
      @(negedge clk);
      quiet_inputs();
      #1;
      check("none_valid", 32'(m2_to_w_valid), 32'd1);
      check("none_avail", 32'(fwd_if.fwd_val_avail), 32'd1);
      check("none_fwd_we", 32'(fwd_if.rd_we), 32'(b.rd_we));
      check_result("none", b, exp_rd);
    end else if (b.mem_op == MEM_OP_STORE) begin
      for (int c = 0; c <= dly; c++) begin
        @(negedge clk);
        quiet_inputs();
        dmss_store_ready = (c == dly);
        #1;
        check("st_req", 32'(dmss_store_req_valid), 32'd1);
        check("st_addr", dmss_store_addr, b.alu_result & 32'hFFFF_FFFC);
        check("st_data", dmss_store_data, ref_sdata(b));
        check("st_be", 32'(dmss_store_be), 32'(ref_be(b)));
        check("st_valid", 32'(m2_to_w_valid), 32'(c == dly));
        check("st_ready", 32'(m2_ready), 32'(c == 0));
      end
    end else begin
      for (int c = 0; c <= lat; c++) begin
        @(negedge clk);
        quiet_inputs();
        dmss_load_rsp_valid = (c == lat);
        if (c == lat) dmss_load_rsp_data = mem;
        #1;
        check("ld_ready", 32'(m2_ready), 32'(c == 0));
        check("ld_avail", 32'(fwd_if.fwd_val_avail), 32'(c == lat));
        check("ld_fwd_we", 32'(fwd_if.rd_we), 32'(b.rd_we));
        if (b.mem_op == MEM_OP_LOAD) begin
          check("ld_valid", 32'(m2_to_w_valid), 32'(c == lat));
          if (c == lat) check_result("ld", b, exp_rd);
        end else begin
          check("amo_ld_valid", 32'(m2_to_w_valid), 32'd0);
          check("amo_ld_req", 32'(dmss_store_req_valid), 32'd0);
        end
      end
      if (b.mem_op == MEM_OP_AMO) begin
        for (int s = 0; s <= dly; s++) begin
          @(negedge clk);
          quiet_inputs();
          dmss_store_ready = (s == dly);
          #1;
          check("amo_req", 32'(dmss_store_req_valid), 32'd1);
          check("amo_data", dmss_store_data, ref_amo(b.amo_alu_op, mem, b.rs2_val));
          check("amo_be", 32'(dmss_store_be), 32'hF);
          check("amo_addr", dmss_store_addr, b.alu_result & 32'hFFFF_FFFC);
          check("amo_ready", 32'(m2_ready), 32'd0);
          check("amo_avail", 32'(fwd_if.fwd_val_avail), 32'd1);
          check("amo_valid", 32'(m2_to_w_valid), 32'(s == dly));
          if (s == dly) check_result("amo", b, mem);
        end
      end
    end
  endtask

  m1_to_m2_s b;

  initial begin
    quiet_inputs();
    m1_to_m2 = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(m2_ready), 32'd1);
    check("rst_valid", 32'(m2_to_w_valid), 32'd0);
    check("rst_req", 32'(dmss_store_req_valid), 32'd0);
    check("rst_fwd_we", 32'(fwd_if.rd_we), 32'd0);
    rst_n = 1'b1;

    // ALU result passes straight through
    b = mk(MEM_OP_NONE, SIZE_WORD, 1'b0, 32'h0000_1234, 32'h0, RD_SRC_ALU, AMO_SWAP);
    run_txn(b, 32'h0, 0, 0);
    // CSR old value
    b = mk(MEM_OP_NONE, SIZE_WORD, 1'b0, $urandom, 32'h0, RD_SRC_CSR, AMO_SWAP);
    run_txn(b, 32'h0, 0, 0);
    // LB, top lane, signed, response 3 cycles late
    b = mk(MEM_OP_LOAD, SIZE_BYTE, 1'b1, 32'h0000_1003, 32'h0, RD_SRC_MEM, AMO_SWAP);
    run_txn(b, 32'h80FF_FFFF, 3, 0);
    check("lb_plan_val", ref_rd(b, 32'h80FF_FFFF), 32'hFFFF_FF80);
    // SH upper half, ready after 2 cycles
    b = mk(MEM_OP_STORE, SIZE_HALF, 1'b0, 32'h0000_2002, 32'hABCD_1234, RD_SRC_ALU, AMO_SWAP);
    run_txn(b, 32'h0, 0, 2);
    // AMOMAX.W signed compare
    b = mk(MEM_OP_AMO, SIZE_WORD, 1'b0, 32'h0000_3000, 32'h0000_0001, RD_SRC_MEM, AMO_MAX);
    run_txn(b, 32'hFFFF_FFFE, 1, 1);

    // Flush in LOAD_WAIT: DRAIN eats the stale response
    b = mk(MEM_OP_LOAD, SIZE_WORD, 1'b0, 32'h0000_4000, 32'h0, RD_SRC_MEM, AMO_SWAP);
    issue(b);
    @(negedge clk); quiet_inputs(); #1;
    check("fl_wait_valid", 32'(m2_to_w_valid), 32'd0);
    @(negedge clk); quiet_inputs(); m2_flush = 1'b1; #1;
    check("fl_valid", 32'(m2_to_w_valid), 32'd0);
    check("fl_ready", 32'(m2_ready), 32'd0);
    @(negedge clk); quiet_inputs(); #1;
    check("drain_ready", 32'(m2_ready), 32'd0);
    check("drain_fwd_we", 32'(fwd_if.rd_we), 32'd0);
    @(negedge clk); quiet_inputs();
    dmss_load_rsp_valid = 1'b1; dmss_load_rsp_data = 32'hDEAD_BEEF; #1;
    check("drain_valid", 32'(m2_to_w_valid), 32'd0);
    @(negedge clk); quiet_inputs(); #1;
    check("drain_done_ready", 32'(m2_ready), 32'd1);
    b = mk(MEM_OP_LOAD, SIZE_WORD, 1'b0, 32'h0000_4004, 32'h0, RD_SRC_MEM, AMO_SWAP);
    run_txn(b, 32'h1122_3344, 1, 0);

    // Stall in LOAD_WAIT: response buffered, completes on first unstalled cycle
    b = mk(MEM_OP_LOAD, SIZE_HALF, 1'b1, 32'h0000_5002, 32'h0, RD_SRC_MEM, AMO_SWAP);
    issue(b);
    @(negedge clk); quiet_inputs(); #1;
    check("stl_c0_valid", 32'(m2_to_w_valid), 32'd0);
    @(negedge clk); quiet_inputs(); m2_stall = 1'b1;
    dmss_load_rsp_valid = 1'b1; dmss_load_rsp_data = 32'h9ABC_0000; #1;
    check("stl_c1_valid", 32'(m2_to_w_valid), 32'd0);
    @(negedge clk); quiet_inputs(); m2_stall = 1'b1; #1;
    check("stl_c2_valid", 32'(m2_to_w_valid), 32'd0);
    check("stl_c2_avail", 32'(fwd_if.fwd_val_avail), 32'd1);
    @(negedge clk); quiet_inputs(); #1;
    check("stl_c3_valid", 32'(m2_to_w_valid), 32'd1);
    check("stl_c3_rd", m2_to_w.rd_val, ref_rd(b, 32'h9ABC_0000));

    // Reset while in STORE_REQ
    b = mk(MEM_OP_STORE, SIZE_WORD, 1'b0, 32'h0000_6000, $urandom, RD_SRC_ALU, AMO_SWAP);
    issue(b);
    @(negedge clk); quiet_inputs(); #1;
    check("rs_req0", 32'(dmss_store_req_valid), 32'd1);
    @(negedge clk); quiet_inputs(); #1;
    check("rs_req1", 32'(dmss_store_req_valid), 32'd1);
    check("rs_busy", 32'(m2_ready), 32'd0);
    rst_n = 1'b0; #1;
    check("rs_req_drop", 32'(dmss_store_req_valid), 32'd0);
    check("rs_ready", 32'(m2_ready), 32'd1);
    check("rs_fwd_we", 32'(fwd_if.rd_we), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rs_after_req", 32'(dmss_store_req_valid), 32'd0);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      mem_op_e   op;
      mem_size_e sz;
      logic [31:0] addr;
      op = mem_op_e'($urandom_range(0, 3));
      sz = (op == MEM_OP_AMO) ? SIZE_WORD : mem_size_e'($urandom_range(0, 2));
      addr = $urandom;
      if (sz == SIZE_HALF) addr = addr & 32'hFFFF_FFFE;
      if (sz == SIZE_WORD) addr = addr & 32'hFFFF_FFFC;
      b = mk(op, sz, 1'($urandom), addr, $urandom,
             (op == MEM_OP_NONE) ? rd_src_e'($urandom_range(0, 1)) :
             (op == MEM_OP_STORE) ? RD_SRC_ALU : RD_SRC_MEM,
             amo_op_e'($urandom_range(0, 8)));
      run_txn(b, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    quiet_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
